// File: rtl/stopwatch_core.sv
// BCD stopwatch core: run/pause/done control, up/down counting with preload, and a multiplexed 7-segment scan.
// Optional lap freeze of the displayed value is compiled in when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
    parameter int DIGITS      = 4,
    parameter int LOAD_DIGITS = 2,
    parameter int DP_POS      = 2
) (
    input  logic                     c_clk,
    input  logic                     R,
    input  logic                     clr,
    input  logic                     P,
    input  logic                     count_tick,
    input  logic                     scan_tick,
    input  logic [1:0]               sel,
    input  logic [4*LOAD_DIGITS-1:0] load,
    input  logic                     lap,
    output logic [4*DIGITS-1:0]      count,
    output logic [DIGITS-1:0]        an,
    output logic [6:0]               sseg,
    output logic                     dp,
    output logic                     done,
    output logic [1:0]               state
);

    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_CLEAR   = 2'b00,
        S_RUNNING = 2'b01,
        S_PAUSED  = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_dir;
    logic                w_nextDir;
    logic [4*DIGITS-1:0] r_count;
    logic [4*DIGITS-1:0] w_nextCount;
    logic [4*DIGITS-1:0] w_loadValue;
    logic [4*DIGITS-1:0] w_stepped;
    logic [4*DIGITS-1:0] w_display;
    logic [SW-1:0]       r_scan;
    logic                w_terminal;
    logic                w_carry;
    logic [3:0]          w_digit;
    logic [3:0]          w_loadNib;
    logic [3:0]          w_shownDigit;

    // Preload value for the CLEAR state; out-of-range load nibbles saturate to 9.
    always_comb begin
        w_loadValue = '0;
        w_loadNib   = '0;
        case (sel)
            2'd2: w_loadValue = ALL_NINES;
            2'd1, 2'd3: begin
                for (int i = 0; i < LOAD_DIGITS; i++) begin
                    w_loadNib = load[4*i +: 4];
                    w_loadValue[4*(DIGITS-LOAD_DIGITS+i) +: 4] = (w_loadNib > 4'd9) ? 4'd9 : w_loadNib;
                end
            end
            default: w_loadValue = '0;
        endcase
    end

    // Ripple a single decimal carry (up) or borrow (down) through all digits.
    always_comb begin
        w_stepped = r_count;
        w_carry   = 1'b1;
        w_digit   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_digit = r_count[4*i +: 4];
            if (w_carry) begin
                if (!r_dir) begin
                    if (w_digit == 4'd9) begin
                        w_stepped[4*i +: 4] = 4'd0;
                    end else begin
                        w_stepped[4*i +: 4] = w_digit + 4'd1;
                        w_carry = 1'b0;
                    end
                end else begin
                    if (w_digit == 4'd0) begin
                        w_stepped[4*i +: 4] = 4'd9;
                    end else begin
                        w_stepped[4*i +: 4] = w_digit - 4'd1;
                        w_carry = 1'b0;
                    end
                end
            end
        end
    end

    assign w_terminal = r_dir ? (r_count == '0) : (r_count == ALL_NINES);

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextDir   = r_dir;
        if (clr && (r_state != S_CLEAR)) begin
            w_nextState = S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    w_nextDir   = sel[1];
                    w_nextCount = w_loadValue;
                    w_nextState = clr ? S_CLEAR : S_PAUSED;
                end
                S_PAUSED: begin
                    if (P) w_nextState = S_RUNNING;
                end
                S_RUNNING: begin
                    // Reaching the terminal value wins over a pause request and stops the count.
                    if (w_terminal) begin
                        w_nextState = S_DONE;
                    end else begin
                        if (count_tick) w_nextCount = w_stepped;
                        if (P) w_nextState = S_PAUSED;
                    end
                end
                default: w_nextState = r_state;
            endcase
        end
    end

    always_ff @(posedge c_clk or posedge R) begin
        if (R) begin
            r_state <= S_CLEAR;
            r_count <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_dir   <= w_nextDir;
        end
    end

    always_ff @(posedge c_clk or posedge R) begin
        if (R) begin
            r_scan <= '0;
        end else if (scan_tick) begin
            r_scan <= (r_scan == SW'(DIGITS-1)) ? '0 : r_scan + SW'(1);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic                r_frozen;
    logic [4*DIGITS-1:0] r_snap;

    always_ff @(posedge c_clk or posedge R) begin
        if (R) begin
            r_frozen <= 1'b0;
            r_snap   <= '0;
        end else if (r_state == S_CLEAR) begin
            r_frozen <= 1'b0;
        end else if (lap && !clr && ((r_state == S_RUNNING) || (r_state == S_PAUSED))) begin
            r_frozen <= !r_frozen;
            if (!r_frozen) r_snap <= r_count;
        end
    end

    assign w_display = r_frozen ? r_snap : r_count;
`else
    logic w_unusedLap;

    assign w_unusedLap = lap;
    assign w_display   = r_count;
`endif

    assign w_shownDigit = w_display[4*r_scan +: 4];

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        sseg = 7'b1111111;
        case (w_shownDigit)
            4'h0: sseg = 7'b1000000;
            4'h1: sseg = 7'b1111001;
            4'h2: sseg = 7'b0100100;
            4'h3: sseg = 7'b0110000;
            4'h4: sseg = 7'b0011001;
            4'h5: sseg = 7'b0010010;
            4'h6: sseg = 7'b0000010;
            4'h7: sseg = 7'b1111000;
            4'h8: sseg = 7'b0000000;
            4'h9: sseg = 7'b0010000;
            4'hA: sseg = 7'b0001000;
            4'hB: sseg = 7'b0000011;
            4'hC: sseg = 7'b1000110;
            4'hD: sseg = 7'b0100001;
            4'hE: sseg = 7'b0000110;
            4'hF: sseg = 7'b0001110;
            default: sseg = 7'b1111111;
        endcase
    end

    assign an    = ~(DIGITS'(1) << r_scan);
    assign dp    = (32'(r_scan) == DP_POS) ? 1'b0 : 1'b1;
    assign done  = (r_state == S_DONE);
    assign state = r_state;
    assign count = r_count;

endmodule
